// File: rtl/fp16_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pkg
// Brief    : binary16 field widths, constants, op encoding and classifiers.
// Revision : 1.0
// ============================================================================
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] FP16_POS_ONE = 16'h3C00;
  localparam logic [15:0] FP16_NEG_ONE = 16'hBC00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp16_t;

  // Subnormals count as zero: this unit flushes them on input.
  function automatic logic is_zero(input logic [15:0] x);
    return x[14:10] == 5'd0;
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : fp16_alu_if
// Brief    : Operand/result bundle between a caller and fp16_alu.
// Revision : 1.0
// ============================================================================
interface fp16_alu_if;
  logic        en;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        valid;

  modport master (output en, op, a, b, input result, valid);
  modport slave  (input en, op, a, b, output result, valid);
endinterface
`default_nettype wire

// File: rtl/fp16_alu_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp16_round_pack
// Brief    : Rounds a normalised significand, packs binary16, handles
//            overflow to Inf and flush-to-zero. FP16_ALU_ROUND_EN selects
//            round-to-nearest-even; otherwise truncation.
// Revision : 1.0
// ============================================================================
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [7:0] exp_unb,
  input  logic [13:0]       sig,      // {1.fraction[10:0], guard, round, sticky}
  output logic [15:0]       fp_out
);

  logic [11:0]       w_man;
  logic signed [8:0] w_exp_b;

`ifdef FP16_ALU_ROUND_EN
  logic w_inc;
  assign w_inc = sig[2] & (sig[1] | sig[0] | sig[3]);
  assign w_man = {1'b0, sig[13:3]} + {11'd0, w_inc};
`else
  logic w_unused_grs;
  assign w_unused_grs = |sig[2:0];
  assign w_man        = {1'b0, sig[13:3]};
`endif

  // A carry out of rounding leaves 1.000..0 one binade higher.
  assign w_exp_b = $signed({exp_unb[7], exp_unb}) + $signed(9'(BIAS))
                 + $signed({8'd0, w_man[11]});

  always_comb begin
    fp_out = {sign, 15'd0};
    if (sig[13]) begin
      if (w_exp_b >= 9'sd31)
        fp_out = {sign, FP16_POS_INF[14:0]};
      else if (w_exp_b > 9'sd0)
        fp_out = {sign, w_exp_b[4:0], w_man[11] ? w_man[10:1] : w_man[9:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp16_alu.sv
`default_nettype none
// ============================================================================
// Module   : fp16_alu
// Brief    : Registered binary16 multiply/add, one result per enabled cycle.
//            FP16_ALU_ROUND_EN enables round-to-nearest-even.
// Revision : 1.0
// ============================================================================
module fp16_alu
  import fp16_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  fp16_alu_if.slave bus
);

  localparam logic signed [7:0] c_bias8 = 8'(BIAS);

  fp16_t w_a, w_b;
  assign w_a = bus.a;
  assign w_b = bus.b;

  // Multiply path
  logic [21:0]       w_prod;
  logic              w_mul_sign;
  logic signed [7:0] w_mul_exp;
  logic [13:0]       w_mul_sig;

  assign w_prod     = 22'({1'b1, w_a.man}) * 22'({1'b1, w_b.man});
  assign w_mul_sign = w_a.sign ^ w_b.sign;
  assign w_mul_exp  = $signed({3'b0, w_a.expo}) + $signed({3'b0, w_b.expo})
                    - c_bias8 - c_bias8 + $signed({7'b0, w_prod[21]});
  assign w_mul_sig  = w_prod[21] ? {w_prod[21:9], |w_prod[8:0]}
                                 : {w_prod[20:8], |w_prod[7:0]};

  // Add path: align the smaller magnitude, keep guard/round/sticky
  logic              w_a_big;
  fp16_t             w_big, w_small;
  logic [4:0]        w_ediff, w_shamt;
  logic [27:0]       w_shifted;
  logic [13:0]       w_small_al, w_big_ext;
  logic [14:0]       w_sum;
  logic [3:0]        w_lz;
  logic              w_add_sign;
  logic signed [7:0] w_add_exp;
  logic [13:0]       w_add_sig;

  assign w_a_big    = w_a[14:0] >= w_b[14:0];
  assign w_big      = w_a_big ? w_a : w_b;
  assign w_small    = w_a_big ? w_b : w_a;
  assign w_ediff    = w_big.expo - w_small.expo;
  assign w_shamt    = (w_ediff > 5'd14) ? 5'd15 : w_ediff;
  assign w_shifted  = {1'b1, w_small.man, 17'd0} >> w_shamt;
  assign w_small_al = {w_shifted[27:15], w_shifted[14] | (|w_shifted[13:0])};
  assign w_big_ext  = {1'b1, w_big.man, 3'b0};
  assign w_sum      = (w_a.sign ^ w_b.sign) ? ({1'b0, w_big_ext} - {1'b0, w_small_al})
                                            : ({1'b0, w_big_ext} + {1'b0, w_small_al});

  always_comb begin
    w_lz = 4'd14;
    for (int i = 0; i < 14; i++)
      if (w_sum[i]) w_lz = 4'(13 - i);
  end

  assign w_add_sig  = w_sum[14] ? {w_sum[14:2], w_sum[1] | w_sum[0]}
                                : (w_sum[13:0] << w_lz);
  assign w_add_exp  = w_sum[14] ? ($signed({3'b0, w_big.expo}) - c_bias8 + 8'sd1)
                                : ($signed({3'b0, w_big.expo}) - c_bias8 - $signed({4'b0, w_lz}));
  // Exact cancellation yields +0 regardless of operand signs.
  assign w_add_sign = (w_sum == 15'd0) ? 1'b0 : w_big.sign;

  logic [15:0] w_packed;

  fp16_round_pack u_round_pack (
    .sign    ((bus.op == OP_MUL) ? w_mul_sign : w_add_sign),
    .exp_unb ((bus.op == OP_MUL) ? w_mul_exp  : w_add_exp),
    .sig     ((bus.op == OP_MUL) ? w_mul_sig  : w_add_sig),
    .fp_out  (w_packed)
  );

  // NaN / Inf / zero operands bypass the arithmetic datapath.
  logic        w_special;
  logic [15:0] w_spec_val;

  always_comb begin
    w_special  = 1'b1;
    w_spec_val = FP16_QNAN;
    if (is_nan(bus.a) || is_nan(bus.b)) begin
      w_spec_val = FP16_QNAN;
    end else if (bus.op == OP_MUL) begin
      if ((is_inf(bus.a) && is_zero(bus.b)) || (is_zero(bus.a) && is_inf(bus.b)))
        w_spec_val = FP16_QNAN;
      else if (is_inf(bus.a) || is_inf(bus.b))
        w_spec_val = {w_mul_sign, FP16_POS_INF[14:0]};
      else if (is_zero(bus.a) || is_zero(bus.b))
        w_spec_val = {w_mul_sign, 15'd0};
      else
        w_special = 1'b0;
    end else begin
      if (is_inf(bus.a) && is_inf(bus.b))
        w_spec_val = (w_a.sign == w_b.sign) ? bus.a : FP16_QNAN;
      else if (is_inf(bus.a))
        w_spec_val = bus.a;
      else if (is_inf(bus.b))
        w_spec_val = bus.b;
      else if (is_zero(bus.a) && is_zero(bus.b))
        w_spec_val = {w_a.sign & w_b.sign, 15'd0};
      else if (is_zero(bus.a))
        w_spec_val = bus.b;
      else if (is_zero(bus.b))
        w_spec_val = bus.a;
      else
        w_special = 1'b0;
    end
  end

  logic [15:0] r_result;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 16'h0000;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.en;
      if (bus.en)
        r_result <= w_special ? w_spec_val : w_packed;
    end
  end

  assign bus.result = r_result;
  assign bus.valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp16_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_alu
// Brief    : Scoreboard bench for fp16_alu against an exact-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_fp16_alu;

`ifdef FP16_ALU_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam logic MUL = 1'b0;
  localparam logic ADD = 1'b1;

  logic clk = 1'b0;
  logic reset;

  fp16_alu_if bus ();

  fp16_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] expv;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
  } txn_t;

  txn_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] hold_val = 16'h0000;

  // Exact value m * 2^e2 rounded to an 11-bit significand, then range-checked.
  function automatic logic [15:0] round_to_fp16(input logic s, input longint unsigned m, input int e2);
    int msb, sh, e;
    longint unsigned keep, rem, half;
    msb = 0;
    for (int i = 0; i < 64; i++) if (m[i]) msb = i;
    if (msb > 10) begin
      sh   = msb - 10;
      keep = m >> sh;
      rem  = m - (keep << sh);
      half = 64'd1 << (sh - 1);
      if (ROUND_EN && ((rem > half) || (rem == half && keep[0]))) keep++;
    end else begin
      keep = m << (10 - msb);
    end
    e = msb + e2;
    if (keep == 64'd2048) begin
      keep = 64'd1024;
      e++;
    end
    if (e + 15 >= 31) return {s, 15'h7C00};
    if (e + 15 <= 0)  return {s, 15'h0000};
    return {s, 5'(e + 15), keep[9:0]};
  endfunction

  function automatic logic [15:0] model(input logic o, input logic [15:0] x, input logic [15:0] y);
    logic   sx, sy, xn, yn, xi, yi, xz, yz;
    int     ex, ey, emin;
    longint mx, my, va, vb, sum;
    sx = x[15]; sy = y[15];
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    mx = longint'({1'b1, x[9:0]}); my = longint'({1'b1, y[9:0]});
    xn = (ex == 31) && (x[9:0] != 0); yn = (ey == 31) && (y[9:0] != 0);
    xi = (ex == 31) && (x[9:0] == 0); yi = (ey == 31) && (y[9:0] == 0);
    xz = (ex == 0); yz = (ey == 0);
    if (xn || yn) return 16'h7E00;
    if (o == MUL) begin
      if ((xi && yz) || (xz && yi)) return 16'h7E00;
      if (xi || yi) return {sx ^ sy, 15'h7C00};
      if (xz || yz) return {sx ^ sy, 15'h0000};
      return round_to_fp16(sx ^ sy, longint'(mx * my), ex + ey - 50);
    end
    if (xi && yi) return (sx == sy) ? x : 16'h7E00;
    if (xi) return x;
    if (yi) return y;
    if (xz && yz) return {sx & sy, 15'h0000};
    if (xz) return y;
    if (yz) return x;
    emin = (ex < ey) ? ex : ey;
    va = mx << (ex - emin);
    vb = my << (ey - emin);
    if (sx) va = -va;
    if (sy) vb = -vb;
    sum = va + vb;
    if (sum == 0) return 16'h0000;
    return round_to_fp16(sum < 0, longint'((sum < 0) ? -sum : sum), emin - 25);
  endfunction

  function automatic logic [15:0] rand_operand(input logic [4:0] near, input bit use_near);
    logic     s;
    logic [9:0] f;
    int       k, e;
    s = 1'($urandom_range(0, 1));
    f = 10'($urandom);
    k = int'($urandom_range(0, 19));
    if (k == 0) return {s, 15'h0000};
    if (k == 1) return {s, 5'h1F, 10'h000};
    if (k == 2) return {s, 5'h1F, f | 10'h001};
    if (k == 3) return {s, 5'h00, f};
    if (use_near && near != 5'd0 && near != 5'd31)
      e = int'(near) + int'($urandom_range(0, 6)) - 3;
    else
      e = int'($urandom_range(1, 30));
    if (e < 1)  e = 1;
    if (e > 30) e = 30;
    return {s, 5'(e), f};
  endfunction

  task automatic drive(input logic r, input logic e, input logic o,
                       input logic [15:0] x, input logic [15:0] y, input logic [15:0] expv);
    @(negedge clk);
    reset  = r;
    bus.en = e;
    bus.op = o;
    bus.a  = x;
    bus.b  = y;
    if (e && !r) sb_q.push_back('{expv: expv, a: x, b: y, op: o});
  endtask

  // Monitor: inputs only change on the falling edge, so they still show what
  // the DUT sampled when read just after the rising edge.
  initial begin : monitor
    txn_t t;
    logic exp_valid;
    forever begin
      @(posedge clk);
      #1;
      exp_valid = !reset && bus.en;
      n_checks++;
      if (bus.valid !== exp_valid) begin
        n_fail++;
        $display("FAIL valid: got %b expected %b at %0t", bus.valid, exp_valid, $time);
      end
      if (reset) begin
        n_checks++;
        if (bus.result !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_result: got %h expected 0000 at %0t", bus.result, $time);
        end
        hold_val = 16'h0000;
      end else if (bus.valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got result %h with no operation pending at %0t", bus.result, $time);
        end else begin
          t = sb_q.pop_front();
          if (bus.result !== t.expv) begin
            n_fail++;
            $display("FAIL result op=%0b a=%h b=%h: got %h expected %h at %0t",
                     t.op, t.a, t.b, bus.result, t.expv, $time);
          end
          hold_val = t.expv;
        end
      end else if (!exp_valid) begin
        n_checks++;
        if (bus.result !== hold_val) begin
          n_fail++;
          $display("FAIL hold: got %h expected %h at %0t", bus.result, hold_val, $time);
        end
      end
    end
  end

  initial begin : stimulus
    logic        o, e, r;
    logic [15:0] x, y;
    reset  = 1'b1;
    bus.en = 1'b0;
    bus.op = 1'b0;
    bus.a  = 16'h0000;
    bus.b  = 16'h0000;
    drive(1'b1, 1'b0, MUL, 16'h0000, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, MUL, 16'h0000, 16'h0000, 16'h0000);

    drive(1'b0, 1'b1, MUL, 16'h3C00, 16'hBC00, 16'hBC00);
    drive(1'b0, 1'b1, MUL, 16'h3E00, 16'h3E00, 16'h4080);
    drive(1'b0, 1'b1, ADD, 16'h3C00, 16'h3C00, 16'h4000);
    drive(1'b0, 1'b1, ADD, 16'h3C00, 16'hBC00, 16'h0000);
    drive(1'b0, 1'b1, MUL, 16'h3C00, 16'hBC00, 16'hBC00);
    drive(1'b0, 1'b1, ADD, 16'h4000, 16'hBC00, 16'h3C00);
    drive(1'b0, 1'b1, ADD, 16'h3C01, 16'h1000, ROUND_EN ? 16'h3C02 : 16'h3C01);
    drive(1'b0, 1'b1, MUL, 16'h7BFF, 16'h4000, 16'h7C00);
    drive(1'b0, 1'b1, MUL, 16'h7C00, 16'h0000, 16'h7E00);
    drive(1'b0, 1'b1, ADD, 16'h7C00, 16'hFC00, 16'h7E00);
    drive(1'b0, 1'b1, MUL, 16'h0001, 16'h3C00, 16'h0000);
    drive(1'b0, 1'b1, ADD, 16'h8000, 16'h8000, 16'h8000);
    drive(1'b0, 1'b1, MUL, 16'h8000, 16'h3C00, 16'h8000);
    drive(1'b0, 1'b1, MUL, 16'hFC00, 16'h4000, 16'hFC00);
    drive(1'b0, 1'b1, ADD, 16'h7C00, 16'hBC00, 16'h7C00);
    drive(1'b0, 1'b1, ADD, 16'h7E01, 16'h3C00, 16'h7E00);

    drive(1'b0, 1'b1, ADD, 16'h3C00, 16'h3C00, 16'h4000);
    drive(1'b0, 1'b0, ADD, 16'h1234, 16'h5678, 16'h0000);
    drive(1'b0, 1'b0, MUL, 16'h7E00, 16'h7E00, 16'h0000);

    drive(1'b0, 1'b1, MUL, 16'h4000, 16'h4000, 16'h4400);
    drive(1'b1, 1'b1, ADD, 16'h3C00, 16'h3C00, 16'h0000);
    drive(1'b0, 1'b1, MUL, 16'h3E00, 16'h3E00, 16'h4080);

    for (int i = 0; i < 3000; i++) begin
      o = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 99) == 0);
      x = rand_operand(5'd0, 1'b0);
      y = rand_operand(x[14:10], $urandom_range(0, 1) == 1);
      drive(r, e, o, x, y, model(o, x, y));
    end

    drive(1'b0, 1'b0, MUL, 16'h0000, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, MUL, 16'h0000, 16'h0000, 16'h0000);
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp16_alu.md
# fp16_alu

Registered IEEE 754 binary16 (half-precision) arithmetic unit that performs either a multiply or an add of two operands per enabled cycle. It is the shared floating-point primitive under the perceptron training datapath, used for the weighted sum v = w0·x0 + w1·x1 + w2·x2 and for weight updates. Subtraction is done by the caller, who multiplies by −1.0 (0xBC00) and then adds.

## Interface
- No parameters; the format is fixed at binary16 (1 sign, 5 exponent with bias 15, 10 fraction bits).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- en  in  1  when high, capture and compute this cycle; when low, outputs hold.
- op  in  1  0 = multiply (a·b), 1 = add (a+b).
- a  in  16  binary16 operand A.
- b  in  16  binary16 operand B.
- result  out  16  binary16 result, registered.
- valid  out  1  high for one cycle when result was updated by an enabled operation.

## Operation
- Multiply: the result sign is sign(a) XOR sign(b). The exponent is ea + eb − 15. The 11×11 significand product is normalised by at most 1 position.
- Add: align the smaller-magnitude operand by right-shifting it. Keep guard, round and sticky bits. Add or subtract the magnitudes. Normalise with a leading-zero count.
- Subnormal inputs are treated as ±0 (sign kept). Results below the minimum normal flush to signed zero.
- Overflow (biased exponent ≥ 31 after rounding) returns ±Inf (0x7C00/0xFC00).
- Any NaN input, Inf·0, or Inf + (−Inf) returns the canonical quiet NaN 0x7E00.
- Inf·finite-nonzero returns signed Inf. Inf + finite returns that Inf.
- Exact cancellation x + (−x) returns +0 (0x0000). (−0) + (−0) returns −0. Zero·x returns a zero with the XOR sign.
- Rounding is round-to-nearest-even when FP16_ALU_ROUND_EN is defined. Otherwise it is truncation (see Configuration).

## Timing
- Latency is 1 cycle. Operands sampled on edge N with en=1 appear on result, with valid=1, after edge N.
- en=0 on an edge: result holds its previous value and valid=0.
- Back-to-back enabled cycles give one result per cycle. There is no stall and no backpressure.
- Reset dominates en. After a reset edge, result=0x0000 and valid=0. An operation issued in the same cycle as reset is discarded.
- op, a and b are only sampled when en=1. Their values while en=0 have no effect.

## Configuration
- FP16_ALU_ROUND_EN defined: round-to-nearest-even, using guard, round and sticky. A mantissa carry-out on rounding increments the exponent and may overflow to Inf.
- FP16_ALU_ROUND_EN undefined: truncation toward zero. Guard, round and sticky are discarded and there is no increment logic. Overflow still yields Inf.

## Structure
- Package fp16_pkg holds:
  - field widths EXP_W=5, MAN_W=10 and BIAS=15;
  - constants FP16_POS_ONE=0x3C00, FP16_NEG_ONE=0xBC00, FP16_QNAN=0x7E00, FP16_POS_INF=0x7C00;
  - the op encoding OP_MUL=0, OP_ADD=1;
  - classify helpers (is_zero, is_inf, is_nan).
- One sub-module, fp16_round_pack, is shared by both paths. It takes sign, an unbiased exponent and a significand with guard/round/sticky. It outputs the packed 16-bit value and handles rounding, overflow to Inf and flush-to-zero.
- The multiply and add datapaths are combinational in the top module. The result and valid registers sit at the output.

## Test plan
- Multiply 0x3C00 · 0xBC00 (1·−1) → 0xBC00. Multiply 0x3E00 · 0x3E00 (1.5·1.5) → 0x4080 (2.25). Each has valid=1 one cycle after the enabled edge.
- Add 0x3C00 + 0x3C00 → 0x4000. Add 0x3C00 + 0xBC00 → 0x0000 (+0). Subtract idiom: a mul by 0xBC00 then an add gives 0x4000 − 0x3C00 → 0x3C00.
- Rounding: 0x3C01 + 0x1000 (a tie) → 0x3C02 with FP16_ALU_ROUND_EN, 0x3C01 without it.
- Specials:
  - 0x7BFF · 0x4000 → 0x7C00.
  - 0x7C00 · 0x0000 → 0x7E00.
  - 0x7C00 + 0xFC00 → 0x7E00.
  - 0x0001 (subnormal) · 0x3C00 → 0x0000.
- Hold: issue 0x3C00+0x3C00 with en=1, then drop en to 0 with new operands. result stays 0x4000 and valid=0.
- Reset: assert reset together with en=1 mid-stream. Next cycle result=0x0000 and valid=0. The first enabled operation after reset is released produces a correct result after 1 cycle.
